// File: rtl/sd_spi_if.sv
// sd_spi_if: host-side control signals and SD card SPI pins of sd_spi_master.
interface sd_spi_if;
   logic       ce;
   logic [1:0] div;
   logic       start;
   logic [7:0] tx_data;
   logic       cs_wr;
   logic       cs_din;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;
   logic       sd_clk;
   logic       sd_mosi;
   logic       sd_miso;
   logic       sd_cs_n;
   modport master(
      input  ce, div, start, tx_data, cs_wr, cs_din, sd_miso,
      output rx_data, busy, done, sd_clk, sd_mosi, sd_cs_n
   );
   modport slave(
      output ce, div, start, tx_data, cs_wr, cs_din, sd_miso,
      input  rx_data, busy, done, sd_clk, sd_mosi, sd_cs_n
   );
endinterface

// File: rtl/sd_spi_master.sv
// sd_spi_master: mode-0 SPI byte master for SD cards, runtime SCLK half-period of (div+1) ce ticks.
module sd_spi_master (
   input logic       clk,
   input logic       reset_n,
   sd_spi_if.master  b
);
   localparam logic [1:0] IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2;
   logic [1:0] state;
   logic [6:0] tx_sh;
   logic [7:0] rx_sh;
   logic [7:0] rx_q;
   logic [1:0] div_q;
   logic [1:0] hcnt;
   logic [2:0] bcnt;
   logic       busy_q, done_q, clk_q, mosi_q, cs_q;
   logic       phase_end;
   assign phase_end = b.ce && (hcnt == div_q);
   assign b.rx_data = rx_q;
   assign b.busy    = busy_q;
   assign b.done    = done_q;
   assign b.sd_clk  = clk_q;
   assign b.sd_mosi = mosi_q;
   assign b.sd_cs_n = cs_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         tx_sh  <= '0;
         rx_sh  <= '0;
         rx_q   <= 8'hFF;
         div_q  <= '0;
         hcnt   <= '0;
         bcnt   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         clk_q  <= 1'b0;
         mosi_q <= 1'b1;
         cs_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (b.cs_wr) cs_q <= b.cs_din;
         case (state)
            IDLE: if (b.start) begin
               tx_sh  <= b.tx_data[6:0];
               mosi_q <= b.tx_data[7];
               div_q  <= b.div;
               hcnt   <= '0;
               bcnt   <= '0;
               busy_q <= 1'b1;
               state  <= LOW;
            end
            LOW: if (phase_end) begin
               hcnt  <= '0;
               clk_q <= 1'b1;
               rx_sh <= {rx_sh[6:0], b.sd_miso};
               state <= HIGH;
            end else if (b.ce) hcnt <= hcnt + 2'd1;
            HIGH: if (phase_end) begin
               hcnt  <= '0;
               clk_q <= 1'b0;
               if (bcnt == 3'd7) begin
                  rx_q   <= rx_sh;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  mosi_q <= 1'b1;
                  state  <= IDLE;
               end else begin
                  mosi_q <= tx_sh[6];
                  tx_sh  <= {tx_sh[5:0], 1'b0};
                  bcnt   <= bcnt + 3'd1;
                  state  <= LOW;
               end
            end else if (b.ce) hcnt <= hcnt + 2'd1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: randomized byte transfers checked against a card/timing model derived from the SPI rules.
module tb_sd_spi_master;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   sd_spi_if b();
   sd_spi_master dut (.clk(clk), .reset_n(reset_n), .b(b.master));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One byte transfer; the card model presents pat MSB-first and the bench
   // expects tx at the rising edges, 16*(div+1) ce ticks to done.
   task automatic xfer(input logic [7:0] tx, input logic [7:0] pat, input logic [1:0] dv,
                       input int cep, input int dup_at, input int cs_at, input int rst_rise);
      logic [7:0] mosi_got = '0;
      int rises = 0, ticks = 0, t_rise = 0, c_rise = 0, cyc = 0;
      logic prev_clk = 1'b0, ce_q;
      bit fin = 0;
      b.sd_miso = pat[7];
      b.tx_data = tx;
      b.div = dv;
      b.start = 1'b1;
      b.ce = 1'b0;
      b.cs_wr = 1'b0;
      @(posedge clk); #1;
      b.start = 1'b0;
      check("busy_acc", b.busy, 1);
      check("done_idle", b.done, 0);
      check("mosi_first", b.sd_mosi, tx[7]);
      while (!fin && cyc < 80 * cep) begin
         cyc++;
         b.ce = (cyc % cep == 0);
         b.start = (cyc == dup_at);
         b.tx_data = 8'($urandom);
         b.div = 2'($urandom);
         b.cs_wr = (cyc == cs_at);
         b.cs_din = 1'b0;
         ce_q = b.ce;
         @(posedge clk); #1;
         b.start = 1'b0;
         b.cs_wr = 1'b0;
         if (ce_q) ticks++;
         if (cyc == cs_at) check("cs_n_low", b.sd_cs_n, 0);
         if (b.sd_clk && !prev_clk) begin
            mosi_got = {mosi_got[6:0], b.sd_mosi};
            rises++;
            t_rise = ticks;
            c_rise = cyc;
            if (rises < 8) b.sd_miso = pat[7-rises];
         end
         if (!b.sd_clk && prev_clk) begin
            check("high_ticks", ticks - t_rise, dv + 1);
            check("high_clks", cyc - c_rise, (dv + 1) * cep);
         end
         prev_clk = b.sd_clk;
         if (rst_rise != 0 && rises == rst_rise) begin
            #2 reset_n = 1'b0;
            #1;
            check("rst_sd_clk", b.sd_clk, 0);
            check("rst_mosi", b.sd_mosi, 1);
            check("rst_cs_n", b.sd_cs_n, 1);
            check("rst_busy", b.busy, 0);
            check("rst_rx", b.rx_data, 8'hFF);
            repeat (3) begin
               @(posedge clk); #1;
               check("rst_no_done", b.done, 0);
            end
            reset_n = 1'b1;
            @(posedge clk); #1;
            check("rst_rx_after", b.rx_data, 8'hFF);
            check("rst_no_done2", b.done, 0);
            fin = 1;
         end else if (b.done) begin
            fin = 1;
            check("done_ticks", ticks, 16 * (dv + 1));
            check("rises", rises, 8);
            check("mosi_bits", mosi_got, tx);
            check("rx_data", b.rx_data, pat);
            check("busy_end", b.busy, 0);
            check("mosi_idle", b.sd_mosi, 1);
            check("sd_clk_idle", b.sd_clk, 0);
         end else if (b.done !== 1'b0) check("done_early", b.done, 0);
      end
      if (!fin) check("timeout", 0, 1);
      b.ce = 1'b0;
   endtask

   initial begin
      logic [7:0] last_rx, tx, pat;
      logic       cd;
      b.ce = 1'b0; b.div = '0; b.start = 1'b0; b.tx_data = '0;
      b.cs_wr = 1'b0; b.cs_din = 1'b1; b.sd_miso = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_sd_clk", b.sd_clk, 0);
      check("reset_mosi", b.sd_mosi, 1);
      check("reset_cs_n", b.sd_cs_n, 1);
      check("reset_busy", b.busy, 0);
      check("reset_done", b.done, 0);
      check("reset_rx", b.rx_data, 8'hFF);
      reset_n = 1'b1;
      @(posedge clk); #1;
      xfer(8'hA5, 8'h3C, 2'd0, 1, 0, 0, 0);
      xfer(8'($urandom), 8'h96, 2'd3, 3, 0, 0, 0);
      xfer(8'h5A, 8'hC3, 2'd0, 1, 5, 0, 0);
      xfer(8'h81, 8'h7E, 2'd1, 1, 0, 7, 0);
      xfer(8'hF0, 8'h0F, 2'd0, 1, 0, 0, 4);
      xfer(8'h33, 8'hCC, 2'd2, 2, 0, 0, 0);
      xfer(8'h00, 8'h00, 2'd0, 1, 0, 0, 0);
      xfer(8'hFF, 8'hFF, 2'd0, 1, 0, 0, 0);
      last_rx = 8'hFF;
      for (int i = 0; i < 20; i++) begin
         tx = 8'($urandom);
         pat = 8'($urandom);
         xfer(tx, pat, 2'($urandom), int'($urandom_range(1, 3)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0, 0);
         last_rx = pat;
         repeat (int'($urandom_range(0, 3))) begin
            cd = 1'($urandom);
            b.cs_wr = 1'b1;
            b.cs_din = cd;
            @(posedge clk); #1;
            b.cs_wr = 1'b0;
            check("cs_idle", b.sd_cs_n, cd);
            check("rx_hold", b.rx_data, last_rx);
            check("sd_clk_hold", b.sd_clk, 0);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sd_spi_master.md
SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 Parameter: none; the half-period is set at runtime by the div port.
REQ-002 clk  in  1  system clock; the only clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ce  in  1  clock enable; all SPI timing advances only on clk cycles with ce=1.
REQ-005 div  in  2  SCLK half-period is (div+1) ce ticks; sampled at transfer start.
REQ-006 start  in  1  one-clk pulse; begins a byte transfer of tx_data.
REQ-007 tx_data  in  8  byte to shift out, MSB first.
REQ-008 cs_wr  in  1  one-clk pulse; loads cs_din into sd_cs_n.
REQ-009 cs_din  in  1  new chip-select level (1 = deselected).
REQ-010 rx_data  out  8  last fully received byte.
REQ-011 busy  out  1  high while a transfer is in progress.
REQ-012 done  out  1  one-clk pulse when rx_data is updated.
REQ-013 sd_clk  out  1  SPI clock, mode 0 (idle low).
REQ-014 sd_mosi  out  1  SPI data to card.
REQ-015 sd_miso  in  1  SPI data from card.
REQ-016 sd_cs_n  out  1  card chip select, active low.

Function
REQ-017 FSM states: IDLE, LOW (sd_clk=0 phase), HIGH (sd_clk=1 phase).
REQ-018 In IDLE, start=1 on any clk cycle (ce not required) latches tx_data into the shift register, latches div, drives sd_mosi=tx_data[7], clears the bit and half-period counters, and sets busy=1 on the next clk; the state becomes LOW.
REQ-019 start while busy=1 is ignored; no queuing.
REQ-020 In LOW and HIGH, the half-period counter increments on each ce tick; the phase ends on the ce tick where the counter equals the latched div, and the counter then clears.
REQ-021 At the end of LOW: sd_clk becomes 1, sd_miso is shifted into the receive register LSB, and the state becomes HIGH.
REQ-022 At the end of HIGH with bit counter <7: sd_clk becomes 0, sd_mosi presents the next bit (MSB-first order), the bit counter increments, and the state becomes LOW.
REQ-023 At the end of HIGH with bit counter =7: sd_clk becomes 0, rx_data loads the receive register, done pulses for exactly one clk, busy becomes 0, sd_mosi returns to 1, and the state becomes IDLE.
REQ-024 A transfer lasts exactly 16*(div+1) ce ticks from the first ce tick after acceptance to done, and produces exactly 8 sd_clk rising edges.
REQ-025 In IDLE, sd_clk=0 and sd_mosi=1.
REQ-026 A change to div during a transfer has no effect until the next start.
REQ-027 cs_wr sets sd_cs_n<=cs_din on the next clk edge in any state; it does not abort or stall an ongoing transfer.
REQ-028 start and cs_wr in the same cycle both take effect.
REQ-029 rx_data holds its value between transfers; it is not modified by cs_wr.

Reset
REQ-030 reset_n=0 asynchronously forces state=IDLE, sd_clk=0, sd_mosi=1, sd_cs_n=1, busy=0, done=0, rx_data=8'hFF, and all counters to 0.
REQ-031 Reset mid-transfer aborts the transfer with no done pulse and leaves rx_data=8'hFF.
REQ-032 After release, the first start is accepted normally.

Verification
REQ-033 With ce=1 constantly, div=0, and start with tx_data=8'hA5 while sd_miso follows the pattern 8'h3C: sd_mosi bits at the rising edges are 1,0,1,0,0,1,0,1; done occurs 16 clk after acceptance; rx_data=8'h3C.
REQ-034 With ce pulsed every 3rd clk and div=3, a start yields 8 sd_clk pulses, each high for 4 ce ticks (12 clk), and done arrives after 64 ce ticks.
REQ-035 A second start issued 5 clk into a transfer is ignored: there is exactly one done pulse and 8 rising edges in total.
REQ-036 cs_wr with cs_din=0 at clk 7 of a transfer gives sd_cs_n=0 at clk 8, and the transfer completes unaffected.
REQ-037 reset_n=0 after the 4th rising edge gives immediate sd_clk=0, sd_mosi=1, sd_cs_n=1, busy=0, and rx_data=8'hFF, with no done pulse.
REQ-038 Back-to-back: start on the clk after done is accepted, and rx_data updates correctly for each of two bytes, 8'h00 and 8'hFF.
